// File: rtl/quic_dec_pix_out_pkg.sv
// Shared types and helpers for the decoder pixel writer.
// State encoding, pixel pack functions and FIFO entry sizing.
package quic_dec_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DATA_W = 32;

    function automatic int fifo_entry_w(input int addr_w);
        return addr_w + DATA_W;
    endfunction

    function automatic logic [31:0] pack_xrgb(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {8'h00, r, g, b};
    endfunction

    function automatic logic [15:0] pack_rgb565(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/quic_dec_pix_out_if.sv
// Pixel-in and memory-write handshakes of the decoder pixel writer.
// The writer itself takes the slave side.
interface quic_dec_pix_out_if #(
    parameter int ADDR_W = 32
);
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_r;
    logic [7:0]        pix_g;
    logic [7:0]        pix_b;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output pix_valid, pix_r, pix_g, pix_b,
        input  pix_ready,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready
    );

    modport slave (
        input  pix_valid, pix_r, pix_g, pix_b,
        output pix_ready,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready
    );
endinterface

// File: rtl/quic_dec_pix_fifo.sv
// Synchronous first-word-fall-through FIFO for {addr, data} write words.
// Output reads as zero while empty so the write bus idles at zero.
module quic_dec_pix_fifo #(
    parameter int W  = 64,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    // Extra pointer bit distinguishes full from empty
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)
                wp <= wp + (AW+1)'(1);
            if (pop && !empty)
                rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/quic_dec_pix_out.sv
// Decoder pixel writer: packs pixels into words and drains them to memory.
// Define QUIC_DEC_RGB565_EN for two RGB565 pixels per word.
module quic_dec_pix_out
    import quic_dec_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       stride,
    quic_dec_pix_out_if.slave bus,
    output logic              busy,
    output logic              frame_done
);
    localparam int EW = fifo_entry_w(ADDR_W);

    logic [1:0]        state;
    logic [15:0]       w_q;
    logic [15:0]       h_q;
    logic [15:0]       stride_q;
    logic [ADDR_W-1:0] row_base;
    logic [15:0]       col;
    logic [15:0]       row;

    logic              accept;
    logic              col_last;
    logic              row_last;
    logic              push;
    logic [ADDR_W-1:0] push_addr;
    logic [31:0]       push_data;
    logic              pend_empty;
    logic [EW-1:0]     fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    assign accept   = bus.pix_valid && bus.pix_ready;
    assign col_last = (col == w_q - 16'd1);
    assign row_last = (row == h_q - 16'd1);

    assign bus.pix_ready = (state == ST_RUN) && !fifo_full;
    assign bus.wr_valid  = !fifo_empty;
    assign bus.wr_addr   = fifo_dout[DATA_W +: ADDR_W];
    assign bus.wr_data   = fifo_dout[DATA_W-1:0];
    assign busy          = (state != ST_IDLE);
    assign frame_done    = (state == ST_DONE);

`ifdef QUIC_DEC_RGB565_EN
    logic        pend_vld;
    logic [15:0] pend_data;
    logic [15:0] p565;

    assign pend_empty = !pend_vld;

    // Even column waits in pend_data; odd column or row end emits the word
    always_comb begin
        p565      = pack_rgb565(bus.pix_r, bus.pix_g, bus.pix_b);
        push      = 1'b0;
        push_data = '0;
        push_addr = row_base + ADDR_W'({col, 1'b0});
        if (accept) begin
            if (col[0]) begin
                push      = 1'b1;
                push_data = {p565, pend_data};
                push_addr = row_base + ADDR_W'({col - 16'd1, 1'b0});
            end else if (col_last) begin
                push      = 1'b1;
                push_data = {16'h0000, p565};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld  <= 1'b0;
            pend_data <= '0;
        end else if (accept) begin
            if (!col[0] && !col_last) begin
                pend_vld  <= 1'b1;
                pend_data <= p565;
            end else begin
                pend_vld  <= 1'b0;
            end
        end
    end
`else
    assign pend_empty = 1'b1;
    assign push       = accept;
    assign push_data  = pack_xrgb(bus.pix_r, bus.pix_g, bus.pix_b);
    assign push_addr  = row_base + ADDR_W'({col, 2'b00});
`endif

    quic_dec_pix_fifo #(
        .W  (EW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({push_addr, push_data}),
        .pop   (bus.wr_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            w_q      <= '0;
            h_q      <= '0;
            stride_q <= '0;
            row_base <= '0;
            col      <= '0;
            row      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        w_q      <= width;
                        h_q      <= height;
                        stride_q <= stride;
                        row_base <= base_addr;
                        col      <= '0;
                        row      <= '0;
                        if (width == 16'd0 || height == 16'd0)
                            state <= ST_DONE;
                        else
                            state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (col_last) begin
                            col      <= '0;
                            row      <= row + 16'd1;
                            row_base <= row_base + ADDR_W'(stride_q);
                            if (row_last)
                                state <= ST_DRAIN;
                        end else begin
                            col <= col + 16'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && pend_empty)
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quic_dec_pix_out.sv
// Scoreboard bench for quic_dec_pix_out; define QUIC_DEC_RGB565_EN
// to exercise the RGB565 packing build instead of xRGB8888.
module tb_quic_dec_pix_out;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [15:0] width;
    logic [15:0] height;
    logic [31:0] base_addr;
    logic [15:0] stride;
    logic        busy;
    logic        frame_done;

    quic_dec_pix_out_if #(.ADDR_W(32)) bus ();

    quic_dec_pix_out #(
        .FIFO_AW (3),
        .ADDR_W  (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .width       (width),
        .height      (height),
        .base_addr   (base_addr),
        .stride      (stride),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    int acc_cnt = 0;
    int last_acc_cyc = 0;
    int wv_cnt = 0;

    wr_t         exp_q[$];
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];

    logic [15:0] m_w;
    logic [31:0] m_base;
    logic [15:0] m_stride;
    logic [15:0] m_pend;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Single negedge monitor: cycle count, write scoreboard, event capture
    logic stalled = 1'b0;
    wr_t  held;
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("stall_hold", {bus.wr_valid, bus.wr_addr, bus.wr_data},
                      {1'b1, held.a, held.d});
            if (bus.wr_valid) wv_cnt++;
            if (bus.wr_valid && bus.wr_ready) begin
                got_a.push_back(bus.wr_addr);
                got_d.push_back(bus.wr_data);
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected actual=%h/%h required=none",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.wr_addr), 64'(e.a));
                    check("wr_data", 64'(bus.wr_data), 64'(e.d));
                end
            end
            stalled = bus.wr_valid && !bus.wr_ready;
            held    = '{a: bus.wr_addr, d: bus.wr_data};
            if (bus.pix_valid && bus.pix_ready) begin
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send_pix(input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
        int  n = 0;
        bit  ok = 0;
        bus.pix_valid = 1'b1;
        bus.pix_r = r;
        bus.pix_g = g;
        bus.pix_b = b;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (bus.pix_ready) ok = 1;
            else n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL pix_accept_timeout actual=%0d required=<500", n);
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
    endtask

    // Model of the expected memory word, then drive the pixel
    task automatic model_send(input int c, input int rw, input logic [7:0] r,
                              input logic [7:0] g, input logic [7:0] b);
        logic [31:0] rb;
        logic [15:0] p;
        rb = m_base + 32'(rw) * 32'(m_stride);
`ifdef QUIC_DEC_RGB565_EN
        p = {r[7:3], g[7:2], b[7:3]};
        if (c % 2 == 0) begin
            if (c == int'(m_w) - 1)
                exp_q.push_back('{a: rb + 32'(2 * c), d: {16'h0000, p}});
            else
                m_pend = p;
        end else begin
            exp_q.push_back('{a: rb + 32'(2 * (c - 1)), d: {p, m_pend}});
        end
`else
        p = 16'h0;
        exp_q.push_back('{a: rb + 32'(4 * c), d: {8'h00, r, g, b}});
`endif
        send_pix(r, g, b);
    endtask

    task automatic start_frame(input logic [15:0] w, input logic [15:0] h,
                               input logic [31:0] base, input logic [15:0] st,
                               output int s);
        m_w = w;
        m_base = base;
        m_stride = st;
        got_a.delete();
        got_d.delete();
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        width = w;
        height = h;
        base_addr = base;
        stride = st;
        s = cyc;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("frame_done_seen", 64'(done_cnt - d0), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pix_k(input int k, input int w);
        model_send(k % w, k / w, 8'(k), 8'(k + 1), 8'(k + 2));
    endtask

    task automatic basic_frame();
        int s, d0, f;
        d0 = done_cnt;
        start_frame(16'd4, 16'd2, 32'h1000, 16'd16, s);
        pix_k(0, 4);
        f = last_acc_cyc;
        for (int k = 1; k < 8; k++) pix_k(k, 4);
        check("throughput", 64'(last_acc_cyc - f), 64'd7);
        wait_done(d0);
        check("basic_nwords", 64'(got_a.size()), 64'd8);
        check("basic_first_addr", 64'(got_a[0]), 64'h1000);
        check("basic_first_data", 64'(got_d[0]), 64'h00000102);
        check("basic_last_addr", 64'(got_a[7]), 64'h101C);
        check("basic_done_lat", 64'(done_cyc - last_wr_cyc), 64'd2);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int s, d0, rh, wv0;
        reset = 1'b1;
        frame_start = 1'b0;
        width = '0;
        height = '0;
        base_addr = '0;
        stride = '0;
        bus.pix_valid = 1'b0;
        bus.pix_r = '0;
        bus.pix_g = '0;
        bus.pix_b = '0;
        bus.wr_ready = 1'b1;
        m_pend = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs",
              {bus.pix_ready, bus.wr_valid, busy, frame_done, bus.wr_addr, bus.wr_data[27:0]},
              64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef QUIC_DEC_RGB565_EN
        d0 = done_cnt;
        start_frame(16'd3, 16'd1, 32'h2000, 16'd16, s);
        model_send(0, 0, 8'hFF, 8'h00, 8'h00);
        model_send(1, 0, 8'h00, 8'hFF, 8'h00);
        model_send(2, 0, 8'h00, 8'h00, 8'hFF);
        wait_done(d0);
        check("rgb565_nwords", 64'(got_a.size()), 64'd2);
        check("rgb565_w0", {got_a[0], got_d[0]}, {32'h2000, 32'h07E0F800});
        check("rgb565_w1", {got_a[1], got_d[1]}, {32'h2004, 32'h0000001F});
`else
        basic_frame();

        // Backpressure: 4x3 frame so the ninth pixel meets a full FIFO
        bus.wr_ready = 1'b0;
        d0 = done_cnt;
        start_frame(16'd4, 16'd3, 32'h1000, 16'd16, s);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                frame_start = 1'b1;
                width = 16'd1;
                height = 16'd1;
                base_addr = 32'hDEAD0000;
            end
            pix_k(k, 4);
            frame_start = 1'b0;
        end
        bus.pix_valid = 1'b1;
        bus.pix_r = 8'd8;
        bus.pix_g = 8'd9;
        bus.pix_b = 8'd10;
        rh = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.pix_ready) rh++;
        end
        check("full_blocks_pix", 64'(rh), 64'd0);
        check("busy_running", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        bus.wr_ready = 1'b1;
        for (int k = 8; k < 12; k++) pix_k(k, 4);
        wait_done(d0);
        check("bp_nwords", 64'(got_a.size()), 64'd12);
        check("bp_addr7", 64'(got_a[7]), 64'h101C);

        // Stride wrap
        d0 = done_cnt;
        start_frame(16'd3, 16'd2, 32'h0, 16'd64, s);
        for (int k = 0; k < 6; k++) pix_k(k, 3);
        wait_done(d0);
        check("stride_r1", {got_a[3], got_a[4]}, {32'h40, 32'h44});
        check("stride_r1c2", 64'(got_a[5]), 64'h48);

        // Reset mid-frame after three pixels
        start_frame(16'd4, 16'd2, 32'h1000, 16'd16, s);
        for (int k = 0; k < 3; k++) pix_k(k, 4);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midreset_outs",
              {bus.pix_ready, bus.wr_valid, busy, frame_done, bus.wr_addr, bus.wr_data[27:0]},
              64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        basic_frame();
`endif

        // Degenerate frames: no writes, frame_done two cycles after start
        for (int t = 0; t < 2; t++) begin
            d0 = done_cnt;
            wv0 = wv_cnt;
            if (t == 0) start_frame(16'd0, 16'd5, 32'h3000, 16'd16, s);
            else        start_frame(16'd3, 16'd0, 32'h3000, 16'd16, s);
            wait_done(d0);
            check("degen_done_lat", 64'(done_cyc - s), 64'd2);
            repeat (4) @(negedge clk);
            #1;
            check("degen_one_pulse", 64'(done_cnt - d0), 64'd1);
            check("degen_no_writes", 64'(wv_cnt - wv0), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
